// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants for the instruction fetch memory: default widths and
// the field layout used to recognise a self-jump (halt) instruction.
package instr_fetch_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  // Jump opcode and where it lives in the instruction word.
  localparam logic [5:0] OPC_JUMP = 6'b010100;
  localparam int         OPC_MSB  = 31;
  localparam int         OPC_LSB  = 26;

  // Jump target field occupies the low bits of the instruction.
  localparam int         TGT_W    = 16;

  function automatic logic opc_is_jump(input logic [5:0] opc);
    return opc == OPC_JUMP;
  endfunction

endpackage

// File: rtl/instr_rsp_fifo.sv
// Two-entry response buffer. Each entry carries {instr, fetch address, oor}.
// A push is taken when there is room or when the head is leaving on the same
// edge, so a full buffer can accept and drain at once without loss.
module instr_rsp_fifo #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         full_o
);

  logic [W-1:0] ent_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q,    cnt_d;
  logic         do_push,  do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Next pointer and occupancy from this cycle's push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = !wr_ptr_q;
    if (do_pop)  rd_ptr_d = !rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the buffer and drops anything in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry payload; never reset, it is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) ent_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = ent_q[rd_ptr_q];
  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: word-addressed program store with a load port,
// single-cycle fetch into a two-entry response buffer, out-of-range word
// substitution and sticky self-jump (halt) detection on delivery.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = 65536,
  parameter logic [DATA_W-1:0] OOR_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_oor,
  input  logic              rsp_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              halted
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = DATA_W + ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req_oor, load_oor;
  logic              accept, pop;
  logic [DATA_W-1:0] rd_word;
  logic [FW-1:0]     push_data, head;
  logic              fifo_valid, fifo_full;
  logic [DATA_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_addr;
  logic              head_oor;
  logic              head_self_jump;
  logic              halted_q, halted_d;

  // Range checks use one extra bit so DEPTH == 2**ADDR_W stays representable.
  assign req_oor  = ({1'b0, req_addr}  >= (ADDR_W+1)'(DEPTH));
  assign load_oor = ({1'b0, load_addr} >= (ADDR_W+1)'(DEPTH));

  // A load owns the cycle; the consumer may still drain buffered responses.
  assign pop       = fifo_valid && rsp_ready;
  assign req_ready = !load_en && (!fifo_full || pop);
  assign accept    = req_valid && req_ready;

  // Out-of-range fetches never touch the array.
  assign rd_word   = req_oor ? OOR_WORD : mem_q[req_addr[IDX_W-1:0]];
  assign push_data = {rd_word, req_addr, req_oor};

  // Program store write port; out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (load_en && !load_oor) mem_q[load_addr[IDX_W-1:0]] <= load_data;
  end

  instr_rsp_fifo #(
    .W (FW)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full)
  );

  assign head_instr = head[FW-1 -: DATA_W];
  assign head_addr  = head[ADDR_W:1];
  assign head_oor   = head[0];

  // Self-jump: jump opcode whose target equals the word's own fetch address.
  assign head_self_jump = opc_is_jump(head_instr[OPC_MSB:OPC_LSB]) &&
                          ({{ADDR_W{1'b0}}, head_instr[TGT_W-1:0]} ==
                           {{TGT_W{1'b0}}, head_addr});

  // Outputs read zero whenever the buffer is empty.
  assign rsp_valid = fifo_valid;
  assign rsp_instr = fifo_valid ? head_instr : '0;
  assign rsp_oor   = fifo_valid && head_oor;

  // Halt sets when a self-jump is handed over; any load clears it and wins.
  always_comb begin
    halted_d = halted_q;
    if (pop && head_self_jump) halted_d = 1'b1;
    if (load_en)               halted_d = 1'b0;
  end

  // Sticky halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted = halted_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem. Two instances share the stimulus: a
// 64-word one for ordering/halt/load tests and a 16-word one for range tests.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;

  logic        b_req_ready, b_rsp_valid, b_rsp_oor, b_halted;
  logic [31:0] b_rsp_instr;
  logic        s_req_ready, s_rsp_valid, s_rsp_oor, s_halted;
  logic [31:0] s_rsp_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .OOR_WORD(32'h0)) u_big (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_instr(b_rsp_instr), .rsp_oor(b_rsp_oor),
    .rsp_ready(rsp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .halted(b_halted)
  );

  instr_fetch_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(16), .OOR_WORD(32'hDEADBEEF)) u_small (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(s_req_ready),
    .rsp_valid(s_rsp_valid), .rsp_instr(s_rsp_instr), .rsp_oor(s_rsp_oor),
    .rsp_ready(rsp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .halted(s_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  b_rsp_valid, 32'd0);
    chk("rst_instr",  b_rsp_instr, 32'd0);
    chk("rst_oor",    b_rsp_oor,   32'd0);
    chk("rst_halted", b_halted,    32'd0);
    chk("rst_ready",  b_req_ready, 32'd1);
    rst = 1'b0;
    tick();

    load(16'd0,  32'h04210000);
    load(16'd19, 32'h50000013);
    load(16'd1,  32'h11111111);
    load(16'd2,  32'h22222222);
    load(16'd3,  32'h33333333);
    load(16'd5,  32'h55555555);

    // In-order fetch, self-jump at 19 halts on delivery.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'd0;
    #1 chk("f0_ready", b_req_ready, 32'd1);
    tick();
    chk("f0_valid", b_rsp_valid, 32'd1);
    chk("f0_instr", b_rsp_instr, 32'h04210000);
    chk("f0_oor",   b_rsp_oor,   32'd0);
    req_addr = 16'd19;
    tick();
    chk("f19_instr",   b_rsp_instr, 32'h50000013);
    chk("f19_nohalt",  b_halted,    32'd0);
    req_valid = 1'b0;
    tick();
    chk("f19_halted",  b_halted,    32'd1);
    chk("f19_drained", b_rsp_valid, 32'd0);

    // Single load pulse clears halt and blocks requests.
    req_valid = 1'b1; req_addr = 16'd0;
    load_en = 1'b1; load_addr = 16'd6; load_data = 32'h66666666;
    #1 chk("ld_blocks", b_req_ready, 32'd0);
    tick();
    load_en = 1'b0; req_valid = 1'b0;
    chk("ld_clr_halt",  b_halted,    32'd0);
    chk("ld_no_accept", b_rsp_valid, 32'd0);

    // Backpressure: two accepted, third stalls, then all three in order.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd1;
    #1 chk("bp_rdy1", b_req_ready, 32'd1);
    tick();
    chk("bp_valid", b_rsp_valid, 32'd1);
    chk("bp_head1", b_rsp_instr, 32'h11111111);
    req_addr = 16'd2;
    #1 chk("bp_rdy2", b_req_ready, 32'd1);
    tick();
    req_addr = 16'd3;
    #1 chk("bp_full_rdy", b_req_ready, 32'd0);
    tick();
    chk("bp_hold", b_rsp_instr, 32'h11111111);
    rsp_ready = 1'b1;
    #1 chk("bp_full_pop_rdy", b_req_ready, 32'd1);
    tick();
    chk("bp_head2", b_rsp_instr, 32'h22222222);
    req_valid = 1'b0;
    tick();
    chk("bp_head3", b_rsp_instr, 32'h33333333);
    tick();
    chk("bp_empty", b_rsp_valid, 32'd0);

    // Read of addr 5 precedes an overwrite of addr 5: old then new.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd5;
    #1 chk("rw_rdy", b_req_ready, 32'd1);
    tick();
    load_en = 1'b1; load_addr = 16'd5; load_data = 32'hA5A5A5A5;
    #1 chk("rw_ld_rdy0", b_req_ready, 32'd0);
    tick();
    chk("rw_old", b_rsp_instr, 32'h55555555);
    chk("rw_ld_rdy1", b_req_ready, 32'd0);
    tick();
    load_en = 1'b0; rsp_ready = 1'b1;
    #1 chk("rw_rdy_after", b_req_ready, 32'd1);
    tick();
    chk("rw_new", b_rsp_instr, 32'hA5A5A5A5);
    req_valid = 1'b0;
    tick();
    chk("rw_empty", b_rsp_valid, 32'd0);

    // Out-of-range on the 16-word instance; load to 20 must not alias to 4.
    load(16'd4,  32'h44444444);
    load(16'd20, 32'h99999999);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'd20;
    tick();
    chk("oor_instr", s_rsp_instr, 32'hDEADBEEF);
    chk("oor_flag",  s_rsp_oor,   32'd1);
    req_addr = 16'd4;
    tick();
    chk("oor_noalias", s_rsp_instr, 32'h44444444);
    chk("oor_flag0",   s_rsp_oor,   32'd0);
    req_valid = 1'b0;
    tick();

    // Async reset with a full buffer and halt set.
    req_valid = 1'b1; req_addr = 16'd19;
    tick();
    req_valid = 1'b0;
    tick();
    chk("ar_halt_pre", b_halted, 32'd1);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 16'd1;
    tick();
    req_addr = 16'd2;
    tick();
    req_valid = 1'b0;
    chk("ar_valid_pre", b_rsp_valid, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",  b_rsp_valid, 32'd0);
    chk("ar_halted", b_halted,    32'd0);
    chk("ar_instr",  b_rsp_instr, 32'd0);
    chk("ar_ready",  b_req_ready, 32'd1);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 16'd2;
    tick();
    chk("ar_mem_kept", b_rsp_instr, 32'h22222222);
    req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
